// File: rtl/shadow_write_scheduler.sv
// Shadow video RAM write scheduler: a bus-snoop write FIFO and a host
// valid/ready port share one registered memory write stage. The host is
// preferred when the FIFO is empty or has been bypassed too long.
module shadow_write_scheduler #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk_logic,
  input  logic                          reset,
  input  logic                          bus_wr_i,
  input  logic [15:0]                   bus_addr_i,
  input  logic [7:0]                    bus_data_i,
  input  logic                          bus_aux_i,
  input  logic                          host_valid_i,
  output logic                          host_ready_o,
  input  logic [15:0]                   host_addr_i,
  input  logic [7:0]                    host_data_i,
  input  logic                          host_aux_i,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [15:0]                   mem_addr_o,
  output logic [7:0]                    mem_data_o,
  output logic                          mem_aux_o,
  output logic                          mem_src_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        aux;
  } wr_req_t;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  wr_req_t       fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [7:0]    starve_q;
  logic          ovf_q;
  state_t        state_q, state_d;
  wr_req_t       out_q;
  logic          src_q;

  logic fifo_empty, fifo_full, starved, load_ok;
  logic host_xfer, pop, push_ok, load;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign starved    = (starve_q == 8'(STARVE_LIMIT));
  assign load_ok    = (state_q == S_IDLE) || mem_ready_i;
  // Ready may be offered to an idle host only while the FIFO has nothing
  // to send; a starved grant is only meaningful with a request present.
  assign host_ready_o = load_ok && (fifo_empty || (host_valid_i && starved));
  assign host_xfer    = host_valid_i && host_ready_o;
  assign pop          = load_ok && !host_xfer && !fifo_empty;
  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign push_ok      = bus_wr_i && (!fifo_full || pop);
  assign load         = host_xfer || pop;

  assign mem_valid_o = (state_q == S_HOLD);
  assign mem_addr_o  = out_q.addr;
  assign mem_data_o  = out_q.data;
  assign mem_aux_o   = out_q.aux;
  assign mem_src_o   = src_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_logic) begin
    if (push_ok) fifo_q[wr_ptr_q] <= '{addr: bus_addr_i, data: bus_data_i, aux: bus_aux_i};
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (bus_wr_i && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Host starvation counter: counts bypassed cycles of a pending request.
  always_ff @(posedge clk_logic) begin
    if (reset)                             starve_q <= '0;
    else if (host_valid_i && !host_ready_o) begin
      if (!starved) starve_q <= starve_q + 1'b1;
    end else                               starve_q <= '0;
  end

  // Output stage state register.
  always_ff @(posedge clk_logic) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Output stage next state: fill on any load, drain when consumed empty-handed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (load) state_d = S_HOLD;
      S_HOLD: if (mem_ready_i && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage payload; held unchanged unless a new write is loaded.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      out_q <= '0;
      src_q <= 1'b0;
    end else if (host_xfer) begin
      out_q <= '{addr: host_addr_i, data: host_data_i, aux: host_aux_i};
      src_q <= 1'b1;
    end else if (pop) begin
      out_q <= fifo_q[rd_ptr_q];
      src_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shadow_write_scheduler.sv
// Bench for shadow_write_scheduler: directed scenarios plus random traffic,
// all checked against a queue-based transaction model.
module tb_shadow_write_scheduler;
  localparam int D = 4;
  localparam int L = 8;

  logic        clk_logic = 1'b0;
  logic        reset;
  logic        bus_wr_i, bus_aux_i, host_valid_i, host_aux_i, mem_ready_i;
  logic [15:0] bus_addr_i, host_addr_i;
  logic [7:0]  bus_data_i, host_data_i;
  logic        host_ready_o, mem_valid_o, mem_aux_o, mem_src_o, overflow_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_data_o;
  logic [2:0]  level_o;

  shadow_write_scheduler #(.FIFO_DEPTH(D), .STARVE_LIMIT(L)) dut (
    .clk_logic(clk_logic), .reset(reset),
    .bus_wr_i(bus_wr_i), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i), .bus_aux_i(bus_aux_i),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .host_addr_i(host_addr_i), .host_data_i(host_data_i), .host_aux_i(host_aux_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_aux_o(mem_aux_o), .mem_src_o(mem_src_o),
    .level_o(level_o), .overflow_o(overflow_o)
  );

  always #5 clk_logic = ~clk_logic;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        x;
  } ent_t;

  // Model state: queued bus writes, the held write and bookkeeping.
  ent_t        q[$];
  bit          m_v, m_src, m_ovf, m_hr, was_rst;
  ent_t        m_e;
  int          m_starve;
  int          checks = 0, failures = 0;
  int          bypass_cnt;
  logic [15:0] emitted[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check the combinational
  // handshake, advance the model at the edge, then check registered outputs.
  task automatic tick();
    bit load_ok, empty, consumed;
    #1;
    load_ok = !m_v || mem_ready_i;
    empty   = (q.size() == 0);
    m_hr    = load_ok && (empty || (host_valid_i && m_starve == L));
    if (!reset) chk("host_ready", host_ready_o, m_hr);
    if (mem_valid_o && mem_ready_i && !reset) emitted.push_back(mem_addr_o);
    if (host_valid_i && !m_hr) bypass_cnt++;
    @(posedge clk_logic);
    if (reset) begin
      q.delete(); m_v = 0; m_e = '0; m_src = 0; m_ovf = 0; m_starve = 0;
      was_rst = 1;
    end else begin
      was_rst  = 0;
      consumed = m_v && mem_ready_i;
      if (host_valid_i && m_hr) begin
        m_v = 1; m_src = 1; m_e = '{a: host_addr_i, d: host_data_i, x: host_aux_i};
      end else if (load_ok && !empty) begin
        m_v = 1; m_src = 0; m_e = q.pop_front();
      end else if (consumed) m_v = 0;
      if (bus_wr_i) begin
        if (q.size() < D) q.push_back('{a: bus_addr_i, d: bus_data_i, x: bus_aux_i});
        else m_ovf = 1;
      end
      if (host_valid_i && !m_hr) m_starve = (m_starve < L) ? m_starve + 1 : L;
      else m_starve = 0;
    end
    @(negedge clk_logic);
    chk("mem_valid", mem_valid_o, m_v);
    chk("level", level_o, q.size());
    chk("overflow", overflow_o, m_ovf);
    if (m_v || was_rst) begin
      chk("mem_addr", mem_addr_o, m_e.a);
      chk("mem_data", mem_data_o, m_e.d);
      chk("mem_aux", mem_aux_o, m_e.x);
      chk("mem_src", mem_src_o, m_src);
    end
  endtask

  task automatic idle_inputs();
    bus_wr_i = 0; bus_addr_i = '0; bus_data_i = '0; bus_aux_i = 0;
    host_valid_i = 0; host_addr_i = '0; host_data_i = '0; host_aux_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic x);
    bus_wr_i = 1; bus_addr_i = a; bus_data_i = d; bus_aux_i = x;
  endtask

  initial begin
    bit hv;
    reset = 1; mem_ready_i = 1; idle_inputs();
    // Reset state
    tick(); reset = 0;
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_addr", mem_addr_o, 0);

    // 1: single bus write appears two edges later, exactly once
    emitted.delete();
    bus(16'h2000, 8'hA5, 0); tick();
    chk("t1_not_yet", mem_valid_o, 0);
    idle_inputs(); tick();
    chk("t1_valid", mem_valid_o, 1);
    chk("t1_addr", mem_addr_o, 16'h2000);
    chk("t1_data", mem_data_o, 8'hA5);
    chk("t1_src", mem_src_o, 0);
    repeat (3) tick();
    chk("t1_once", emitted.size(), 1);

    // 2: stalled memory, 6 bus writes, last one dropped, then drain in order
    do_reset(); mem_ready_i = 0;
    for (int i = 0; i < 6; i++) begin bus(16'h0400 + 16'(i), 8'(i), 0); tick(); end
    idle_inputs();
    chk("t2_level", level_o, 4);
    chk("t2_ovf", overflow_o, 1);
    emitted.delete(); mem_ready_i = 1;
    repeat (7) tick();
    chk("t2_count", emitted.size(), 5);
    for (int i = 0; i < 5 && i < emitted.size(); i++) chk("t2_order", emitted[i], 16'h0400 + 16'(i));

    // 3: full FIFO, consume and push in the same cycle
    do_reset(); mem_ready_i = 0;
    for (int i = 0; i < 5; i++) begin bus(16'h0800 + 16'(i), 8'(i), 1); tick(); end
    bus(16'h0900, 8'h77, 1); mem_ready_i = 1; tick();
    idle_inputs(); mem_ready_i = 0;
    chk("t3_level", level_o, 4);
    chk("t3_ovf", overflow_o, 0);
    mem_ready_i = 1; repeat (6) tick();

    // 4: host write into an empty scheduler
    do_reset();
    host_valid_i = 1; host_addr_i = 16'h6000; host_data_i = 8'h3C; host_aux_i = 1;
    tick();
    chk("t4_ready", m_hr, 1);
    idle_inputs();
    chk("t4_addr", mem_addr_o, 16'h6000);
    chk("t4_data", mem_data_o, 8'h3C);
    chk("t4_aux", mem_aux_o, 1);
    chk("t4_src", mem_src_o, 1);
    tick();

    // 5: continuous bus traffic starves the host for exactly L cycles
    do_reset(); emitted.delete();
    for (int i = 0; i < 2; i++) begin bus(16'h1000 + 16'(i), 8'(i), 0); tick(); end
    host_valid_i = 1; host_addr_i = 16'h7000; host_data_i = 8'h11; bypass_cnt = 0;
    for (int i = 2; i < 40 && host_valid_i; i++) begin
      bus(16'h1000 + 16'(i), 8'(i), 0); tick();
      if (m_hr) host_valid_i = 0;
    end
    chk("t5_granted", host_valid_i, 0);
    chk("t5_bypass", bypass_cnt, L);
    idle_inputs(); repeat (6) tick();
    begin
      int k = 0;
      foreach (emitted[i]) if (emitted[i] != 16'h7000) begin
        chk("t5_order", emitted[i], 16'h1000 + 16'(k)); k++;
      end
    end

    // 6: reset discards queued and held writes
    do_reset(); mem_ready_i = 0;
    for (int i = 0; i < 4; i++) begin bus(16'h3000 + 16'(i), 8'(i), 0); tick(); end
    idle_inputs();
    chk("t6_pre_level", level_o, 3);
    reset = 1; tick(); reset = 0;
    chk("t6_level", level_o, 0);
    chk("t6_valid", mem_valid_o, 0);
    chk("t6_ovf", overflow_o, 0);
    mem_ready_i = 1; emitted.delete();
    repeat (4) tick();
    chk("t6_silent", emitted.size(), 0);

    // Random traffic against the model
    hv = 0;
    for (int n = 0; n < 600; n++) begin
      bus_wr_i    = ($urandom_range(0, 99) < 55);
      bus_addr_i  = 16'($urandom); bus_data_i = 8'($urandom); bus_aux_i = 1'($urandom);
      mem_ready_i = ($urandom_range(0, 99) < 65);
      if (!hv && $urandom_range(0, 99) < 30) begin
        hv = 1; host_addr_i = 16'($urandom); host_data_i = 8'($urandom); host_aux_i = 1'($urandom);
      end
      host_valid_i = hv;
      reset = ($urandom_range(0, 199) == 0);
      tick();
      if (hv && m_hr && !reset) hv = 0;
      if (reset) hv = 0;
      reset = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
